id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/pipe_pkg.sv | 16 +
 rtl/id_ex_stage_if.sv | 37 +++
 rtl/hazard_detect.sv | 19 +
 rtl/id_ex_stage.sv | 123 ++++++++++++
 tb/tb_id_ex_stage.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline widths and the control bundle produced by the control unit
package pipe_pkg;
  localparam int PIPE_DW = 32;
  localparam int PIPE_RW = 5;
  localparam int ALUOP_W = 6;

  typedef struct packed {
    logic               branch;
    logic               memwrite;
    logic               memtoreg;
    logic               regdst;
    logic               regwrite;
    logic               alusrc;
    logic [ALUOP_W-1:0] aluop;
  } ctrl_t;
endpackage

// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - ID-side inputs and EX-side outputs of the ID/EX register
interface id_ex_stage_if
  import pipe_pkg::*;
#(
  parameter int DW = PIPE_DW,
  parameter int RW = PIPE_RW
);
  logic               ena;
  logic               flush_i;
  logic               branch_i, memwrite_i, memtoreg_i, regdst_i, regwrite_i, alusrc_i;
  logic [ALUOP_W-1:0] aluop_i;
  logic [DW-1:0]      pc4_i, rdata1_i, rdata2_i, imm_i;
  logic [RW-1:0]      rs_i, rt_i, rd_i;
  logic               use_rt_i;

  logic               branch_o, memwrite_o, memtoreg_o, regdst_o, regwrite_o, alusrc_o;
  logic [ALUOP_W-1:0] aluop_o;
  logic [DW-1:0]      pc4_o, rdata1_o, rdata2_o, imm_o;
  logic [RW-1:0]      rs_o, rt_o, rd_o;
  logic               valid_o;
  logic               stall_o;
  logic [15:0]        stall_cnt_o;

  modport master (
    output ena, flush_i, branch_i, memwrite_i, memtoreg_i, regdst_i, regwrite_i, alusrc_i,
           aluop_i, pc4_i, rdata1_i, rdata2_i, imm_i, rs_i, rt_i, rd_i, use_rt_i,
    input  branch_o, memwrite_o, memtoreg_o, regdst_o, regwrite_o, alusrc_o, aluop_o,
           pc4_o, rdata1_o, rdata2_o, imm_o, rs_o, rt_o, rd_o, valid_o, stall_o, stall_cnt_o
  );

  modport slave (
    input  ena, flush_i, branch_i, memwrite_i, memtoreg_i, regdst_i, regwrite_i, alusrc_i,
           aluop_i, pc4_i, rdata1_i, rdata2_i, imm_i, rs_i, rt_i, rd_i, use_rt_i,
    output branch_o, memwrite_o, memtoreg_o, regdst_o, regwrite_o, alusrc_o, aluop_o,
           pc4_o, rdata1_o, rdata2_o, imm_o, rs_o, rt_o, rd_o, valid_o, stall_o, stall_cnt_o
  );
endinterface

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - load-use comparator between the load in EX and the instruction in ID
// Only built with ID_EX_HAZARD_EN; without it the compiler fills load delay slots.
`ifdef ID_EX_HAZARD_EN
module hazard_detect #(
  parameter int RW = 5
) (
  input  logic          valid_i,
  input  logic          memtoreg_i,
  input  logic [RW-1:0] rt_ex_i,
  input  logic [RW-1:0] rs_id_i,
  input  logic [RW-1:0] rt_id_i,
  input  logic          use_rt_i,
  output logic          hazard_o
);
  // r0 is hardwired zero, so a load targeting it never creates a dependency
  assign hazard_o = valid_i & memtoreg_i & (rt_ex_i != '0)
                  & ((rt_ex_i == rs_id_i) | (use_rt_i & (rt_ex_i == rt_id_i)));
endmodule
`endif

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register; ID_EX_HAZARD_EN adds the load-use interlock
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int DW = PIPE_DW,
  parameter int RW = PIPE_RW
) (
  input logic          clk,
  input logic          rst,
  id_ex_stage_if.slave bus
);
  ctrl_t         ctrl_in, ctrl_d, ctrl_q;
  logic          valid_d, valid_q;
  logic [DW-1:0] pc4_d, pc4_q, rdata1_d, rdata1_q, rdata2_d, rdata2_q, imm_d, imm_q;
  logic [RW-1:0] rs_d, rs_q, rt_d, rt_q, rd_d, rd_q;
  logic          hazard, stall;

  assign ctrl_in = {bus.branch_i, bus.memwrite_i, bus.memtoreg_i, bus.regdst_i,
                    bus.regwrite_i, bus.alusrc_i, bus.aluop_i};

`ifdef ID_EX_HAZARD_EN
  logic [15:0] cnt_d, cnt_q;

  hazard_detect #(.RW(RW)) u_hazard (
    .valid_i    (valid_q),
    .memtoreg_i (ctrl_q.memtoreg),
    .rt_ex_i    (rt_q),
    .rs_id_i    (bus.rs_i),
    .rt_id_i    (bus.rt_i),
    .use_rt_i   (bus.use_rt_i),
    .hazard_o   (hazard)
  );

  assign cnt_d = (stall && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign bus.stall_cnt_o = cnt_q;
`else
  logic unused_use_rt;
  assign unused_use_rt   = bus.use_rt_i;
  assign hazard          = 1'b0;
  assign bus.stall_cnt_o = '0;
`endif

  // flush outranks the interlock, and a frozen pipe cannot stall
  assign stall       = hazard & bus.ena & ~bus.flush_i;
  assign bus.stall_o = stall;

  always_comb begin
    ctrl_d   = ctrl_q;
    valid_d  = valid_q;
    pc4_d    = pc4_q;
    rdata1_d = rdata1_q;
    rdata2_d = rdata2_q;
    imm_d    = imm_q;
    rs_d     = rs_q;
    rt_d     = rt_q;
    rd_d     = rd_q;
    if (bus.flush_i) begin
      ctrl_d  = '0;
      valid_d = 1'b0;
    end else if (bus.ena) begin
      if (stall) begin
        ctrl_d  = '0;
        valid_d = 1'b0;
      end else begin
        ctrl_d   = ctrl_in;
        valid_d  = 1'b1;
        pc4_d    = bus.pc4_i;
        rdata1_d = bus.rdata1_i;
        rdata2_d = bus.rdata2_i;
        imm_d    = bus.imm_i;
        rs_d     = bus.rs_i;
        rt_d     = bus.rt_i;
        rd_d     = bus.rd_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q   <= '0;
      valid_q  <= 1'b0;
      pc4_q    <= '0;
      rdata1_q <= '0;
      rdata2_q <= '0;
      imm_q    <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      rd_q     <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      valid_q  <= valid_d;
      pc4_q    <= pc4_d;
      rdata1_q <= rdata1_d;
      rdata2_q <= rdata2_d;
      imm_q    <= imm_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      rd_q     <= rd_d;
    end
  end

  assign bus.branch_o   = ctrl_q.branch;
  assign bus.memwrite_o = ctrl_q.memwrite;
  assign bus.memtoreg_o = ctrl_q.memtoreg;
  assign bus.regdst_o   = ctrl_q.regdst;
  assign bus.regwrite_o = ctrl_q.regwrite;
  assign bus.alusrc_o   = ctrl_q.alusrc;
  assign bus.aluop_o    = ctrl_q.aluop;
  assign bus.valid_o    = valid_q;
  assign bus.pc4_o      = pc4_q;
  assign bus.rdata1_o   = rdata1_q;
  assign bus.rdata2_o   = rdata2_q;
  assign bus.imm_o      = imm_q;
  assign bus.rs_o       = rs_q;
  assign bus.rt_o       = rt_q;
  assign bus.rd_o       = rd_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - scoreboard bench for id_ex_stage, both with and without ID_EX_HAZARD_EN
module tb_id_ex_stage;
  localparam logic [11:0] C_LW  = 12'h2C0;  // memtoreg, regwrite, alusrc
  localparam logic [11:0] C_RT  = 12'h1A0;  // regdst, regwrite, aluop 0x20
  localparam logic [11:0] C_SW  = 12'h440;  // memwrite, alusrc
  localparam logic [11:0] C_BEQ = 12'h801;  // branch, aluop 0x01

  typedef struct packed {
    logic [11:0] ctrl;
    logic        valid;
    logic [31:0] pc4, rdata1, rdata2, imm;
    logic [4:0]  rs, rt, rd;
    logic [15:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_ex_stage_if #(.DW(32), .RW(5)) bus ();
  id_ex_stage #(.DW(32), .RW(5)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  exp_t        m;
  exp_t        sb_q[$];
  logic [11:0] in_ctrl;
  logic [31:0] in_d;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic        in_use_rt;
  int          total = 0;
  int          bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic load_in(input logic [11:0] c, input logic [31:0] d,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic use_rt);
    in_ctrl = c; in_d = d; in_rs = rs; in_rt = rt; in_rd = rd; in_use_rt = use_rt;
    {bus.branch_i, bus.memwrite_i, bus.memtoreg_i, bus.regdst_i,
     bus.regwrite_i, bus.alusrc_i, bus.aluop_i} = c;
    bus.pc4_i    = d + 32'd4;
    bus.rdata1_i = d;
    bus.rdata2_i = ~d;
    bus.imm_i    = d ^ 32'h5a5a_0f0f;
    bus.rs_i     = rs;
    bus.rt_i     = rt;
    bus.rd_i     = rd;
    bus.use_rt_i = use_rt;
  endtask

  // Called just after a falling edge; checks stall_o combinationally, then the registered result.
  task automatic cycle(input logic r, input logic en, input logic fl);
    exp_t nx, e;
    logic hz, st;
    rst = r; bus.ena = en; bus.flush_i = fl;
    #1;
`ifdef ID_EX_HAZARD_EN
    hz = m.valid & m.ctrl[9] & (m.rt != 5'd0)
       & ((m.rt == in_rs) | (in_use_rt & (m.rt == in_rt)));
`else
    hz = 1'b0;
`endif
    st = hz & en & ~fl;
    check_eq("stall_o", {31'd0, bus.stall_o}, {31'd0, st});
    nx = m;
    if (r) begin
      nx = '0;
    end else if (fl) begin
      nx.ctrl = '0; nx.valid = 1'b0;
    end else if (en) begin
      if (st) begin
        nx.ctrl = '0; nx.valid = 1'b0;
        if (nx.cnt != 16'hFFFF) nx.cnt = nx.cnt + 16'd1;
      end else begin
        nx.ctrl = in_ctrl; nx.valid = 1'b1;
        nx.pc4 = in_d + 32'd4; nx.rdata1 = in_d; nx.rdata2 = ~in_d;
        nx.imm = in_d ^ 32'h5a5a_0f0f;
        nx.rs = in_rs; nx.rt = in_rt; nx.rd = in_rd;
      end
    end
    m = nx;
    sb_q.push_back(nx);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check_eq("ctrl", {20'd0, bus.branch_o, bus.memwrite_o, bus.memtoreg_o, bus.regdst_o,
                      bus.regwrite_o, bus.alusrc_o, bus.aluop_o}, {20'd0, e.ctrl});
    check_eq("valid_o", {31'd0, bus.valid_o}, {31'd0, e.valid});
    check_eq("pc4_o", bus.pc4_o, e.pc4);
    check_eq("rdata1_o", bus.rdata1_o, e.rdata1);
    check_eq("rdata2_o", bus.rdata2_o, e.rdata2);
    check_eq("imm_o", bus.imm_o, e.imm);
    check_eq("idx_o", {17'd0, bus.rs_o, bus.rt_o, bus.rd_o}, {17'd0, e.rs, e.rt, e.rd});
    check_eq("stall_cnt_o", {16'd0, bus.stall_cnt_o}, {16'd0, e.cnt});
    @(negedge clk);
  endtask

  initial begin
    m = '0;
    rst = 1'b1; bus.ena = 1'b0; bus.flush_i = 1'b0;
    load_in(12'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);

    // reset state, asserted with ena low
    load_in(C_RT, 32'hdead_beef, 5'd1, 5'd2, 5'd3, 1'b1);
    cycle(1'b1, 1'b0, 1'b0);

    // normal load
    load_in(C_RT, 32'h0000_1234, 5'd1, 5'd2, 5'd3, 1'b1);
    cycle(1'b0, 1'b1, 1'b0);

    // load-use on rs: stall, bubble, then the dependent instruction enters
    load_in(C_LW, 32'h0000_1000, 5'd1, 5'd5, 5'd0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    load_in(C_RT, 32'h0000_2000, 5'd5, 5'd6, 5'd7, 1'b1);
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);

    // load into r0 never interlocks
    load_in(C_LW, 32'h0000_3000, 5'd2, 5'd0, 5'd0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    load_in(C_RT, 32'h0000_3100, 5'd0, 5'd0, 5'd4, 1'b1);
    cycle(1'b0, 1'b1, 1'b0);

    // rt match ignored when ID does not read rt, honoured when it does
    load_in(C_LW, 32'h0000_4000, 5'd1, 5'd7, 5'd0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    load_in(C_SW, 32'h0000_4100, 5'd3, 5'd7, 5'd0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    load_in(C_LW, 32'h0000_4200, 5'd1, 5'd7, 5'd0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    load_in(C_RT, 32'h0000_4300, 5'd3, 5'd7, 5'd8, 1'b1);
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);

    // flush in the same cycle as a load-use hazard
    load_in(C_LW, 32'h0000_5000, 5'd1, 5'd5, 5'd0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    load_in(C_RT, 32'h0000_5100, 5'd5, 5'd6, 5'd7, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b0);

    // freeze three cycles with a hazard pending, then stall, then reset mid-hazard
    load_in(C_BEQ, 32'h0000_abcd, 5'd4, 5'd4, 5'd0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0);
    load_in(C_LW, 32'h0000_6000, 5'd1, 5'd9, 5'd0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    load_in(C_RT, 32'h0000_6100, 5'd9, 5'd2, 5'd3, 1'b1);
    repeat (3) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);

    // random traffic over a small register range to provoke hazards
    for (int i = 0; i < 60; i++) begin
      load_in(12'($urandom), $urandom, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              5'($urandom_range(0, 31)), 1'($urandom));
      cycle(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 4) != 0),
            1'($urandom_range(0, 7) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
